// File: rtl/fill_rect_engine_pkg.sv
// Shared framebuffer geometry, write-mask constants and FSM encoding for the fill engine
// and its row address/mask helper.
package fill_rect_engine_pkg;

  localparam int unsigned FB_WIDTH      = 640;
  localparam int unsigned FB_HEIGHT     = 480;
  localparam int unsigned WORDS_PER_ROW = FB_WIDTH / 4;
  localparam int unsigned FB_ADDR_W     = 17;

  localparam logic [3:0] OP_WR_ALL = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StEmit,
    StDone
  } fill_state_e;

endpackage

// File: rtl/fill_rect_engine_row_calc.sv
// Combinational per-row geometry: word address of the first word in the row, the first and
// last word indices, and the byte-lane masks for the row's edges.
module fill_rect_engine_row_calc
  import fill_rect_engine_pkg::*;
#(
  parameter int unsigned ADDR_W    = FB_ADDR_W,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic [8:0]        y,
  input  logic [9:0]        x0,
  input  logic [10:0]       x_end,
  output logic [ADDR_W-1:0] row_addr,
  output logic [7:0]        first_word,
  output logic [7:0]        last_word,
  output logic [3:0]        first_mask,
  output logic [3:0]        last_mask
);

  logic [10:0]       x_last;
  logic [ADDR_W-1:0] y_ext;

  always_comb begin
    x_last     = x_end - 11'd1;
    y_ext      = ADDR_W'(y);
    // y * 160 as two shifts; the row stride is fixed at 160 words
    row_addr   = ADDR_W'(BASE_ADDR) + (y_ext << 7) + (y_ext << 5) + ADDR_W'(x0[9:2]);
    first_word = x0[9:2];
    last_word  = 8'(x_last >> 2);
    first_mask = OP_WR_ALL << x0[1:0];
    last_mask  = OP_WR_ALL >> (2'd3 - x_last[1:0]);
  end

endmodule

// File: rtl/fill_rect_engine.sv
// Rectangle fill engine: turns one clipped fill command into a row-by-row stream of
// byte-masked 32-bit framebuffer writes toward the memory arbiter.
module fill_rect_engine
  import fill_rect_engine_pkg::*;
#(
  parameter int unsigned ADDR_W    = FB_ADDR_W,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x0,
  input  logic [8:0]        cmd_y0,
  input  logic [9:0]        cmd_w,
  input  logic [8:0]        cmd_h,
  input  logic [7:0]        cmd_color,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] fillrect_addr,
  output logic [31:0]       fillrect_wrdata,
  output logic [3:0]        fillrect_op,
  output logic              fillrect_rts_out,
  input  logic              fillrect_rtr_in
);

  fill_state_e state_q;
  logic [9:0]  x0_q;
  logic [10:0] x_end_q;
  logic [8:0]  y_q;
  logic [8:0]  y_end_q;
  logic [7:0]  color_q;
  logic [7:0]  word_q;
  logic [7:0]  last_word_q;
  logic [3:0]  last_mask_q;

  logic [10:0] x_sum;
  logic [9:0]  y_sum;
  logic [10:0] x_end_in;
  logic [8:0]  y_end_in;
  logic        cmd_empty;
  logic        xfc;

  logic [ADDR_W-1:0] row_addr;
  logic [7:0]        first_word;
  logic [7:0]        last_word;
  logic [3:0]        first_mask;
  logic [3:0]        last_mask;

  // Clip against the visible area at acceptance so the rest of the engine never sees it.
  always_comb begin
    x_sum     = {1'b0, cmd_x0} + {1'b0, cmd_w};
    y_sum     = {1'b0, cmd_y0} + {1'b0, cmd_h};
    x_end_in  = (x_sum > 11'(FB_WIDTH)) ? 11'(FB_WIDTH) : x_sum;
    y_end_in  = (y_sum > 10'(FB_HEIGHT)) ? 9'(FB_HEIGHT) : y_sum[8:0];
    cmd_empty = (cmd_w == 10'd0) | (cmd_h == 9'd0) |
                (cmd_x0 >= 10'(FB_WIDTH)) | (cmd_y0 >= 9'(FB_HEIGHT));
    xfc       = fillrect_rts_out & fillrect_rtr_in;
  end

  fill_rect_engine_row_calc #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_row_calc (
    .y          (y_q),
    .x0         (x0_q),
    .x_end      (x_end_q),
    .row_addr   (row_addr),
    .first_word (first_word),
    .last_word  (last_word),
    .first_mask (first_mask),
    .last_mask  (last_mask)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q          <= StIdle;
      x0_q             <= '0;
      x_end_q          <= '0;
      y_q              <= '0;
      y_end_q          <= '0;
      color_q          <= '0;
      word_q           <= '0;
      last_word_q      <= '0;
      last_mask_q      <= '0;
      cmd_ready        <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      fillrect_addr    <= '0;
      fillrect_wrdata  <= '0;
      fillrect_op      <= '0;
      fillrect_rts_out <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            x0_q      <= cmd_x0;
            x_end_q   <= x_end_in;
            y_q       <= cmd_y0;
            y_end_q   <= y_end_in;
            color_q   <= cmd_color;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_empty) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end

        StCalc: begin
          fillrect_addr    <= row_addr;
          fillrect_wrdata  <= {4{color_q}};
          fillrect_op      <= (first_word == last_word) ? (first_mask & last_mask) : first_mask;
          word_q           <= first_word;
          last_word_q      <= last_word;
          last_mask_q      <= last_mask;
          fillrect_rts_out <= 1'b1;
          state_q          <= StEmit;
        end

        StEmit: begin
          // Outputs hold while stalled; only a completed transfer advances the word.
          if (xfc) begin
            if (word_q < last_word_q) begin
              word_q        <= word_q + 8'd1;
              fillrect_addr <= fillrect_addr + ADDR_W'(1);
              fillrect_op   <= ((word_q + 8'd1) == last_word_q) ? last_mask_q : OP_WR_ALL;
            end else begin
              fillrect_rts_out <= 1'b0;
              if (({1'b0, y_q} + 10'd1) < {1'b0, y_end_q}) begin
                y_q     <= y_q + 9'd1;
                state_q <= StCalc;
              end else begin
                done    <= 1'b1;
                state_q <= StDone;
              end
            end
          end
        end

        StDone: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state_q   <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fill_rect_engine.sv
// Self-checking bench for fill_rect_engine: per-pixel reference model, per-cycle compare
// process, directed cases with literal expectations and a randomized command stream.
module tb_fill_rect_engine;

  typedef struct packed {
    logic [16:0] addr;
    logic [3:0]  op;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst_;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x0;
  logic [8:0]  cmd_y0;
  logic [9:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic        busy;
  logic        done;
  logic [16:0] fillrect_addr;
  logic [31:0] fillrect_wrdata;
  logic [3:0]  fillrect_op;
  logic        fillrect_rts_out;
  logic        fillrect_rtr_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int empty_done_due = -1;
  int final_done_due = -1;
  int rtr_mode = 0;
  int pidx = 0;
  bit chk_en = 0;

  wr_t exp_q[$];
  wr_t log_q[$];

  fill_rect_engine dut (
    .clk              (clk),
    .rst_             (rst_),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_x0           (cmd_x0),
    .cmd_y0           (cmd_y0),
    .cmd_w            (cmd_w),
    .cmd_h            (cmd_h),
    .cmd_color        (cmd_color),
    .busy             (busy),
    .done             (done),
    .fillrect_addr    (fillrect_addr),
    .fillrect_wrdata  (fillrect_wrdata),
    .fillrect_op      (fillrect_op),
    .fillrect_rts_out (fillrect_rts_out),
    .fillrect_rtr_in  (fillrect_rtr_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a word is written iff it holds at least one pixel inside the clipped rectangle;
  // its lane i is enabled iff pixel 4*word+i lies inside.
  task automatic model_cmd(input int x0, input int y0, input int w, input int h,
                           input logic [7:0] c, output bit empty);
    int xe;
    int ye;
    wr_t e;
    xe = (x0 + w > 640) ? 640 : x0 + w;
    ye = (y0 + h > 480) ? 480 : y0 + h;
    empty = (w == 0) || (h == 0) || (x0 >= 640) || (y0 >= 480);
    if (!empty) begin
      for (int y = y0; y < ye; y++) begin
        for (int wd = x0 / 4; wd <= (xe - 1) / 4; wd++) begin
          e.addr = 17'(y * 160 + wd);
          e.data = {4{c}};
          e.op   = 4'b0000;
          for (int i = 0; i < 4; i++) begin
            if ((4 * wd + i) >= x0 && (4 * wd + i) < xe) e.op[i] = 1'b1;
          end
          exp_q.push_back(e);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (rtr_mode)
      0: fillrect_rtr_in = 1'b1;
      1: fillrect_rtr_in = 1'($urandom % 2);
      default: begin
        fillrect_rtr_in = ((pidx % 4) == 0) || ((pidx % 4) == 3);
        pidx++;
      end
    endcase
  end

  // Per-cycle compare against the model queue, sampled mid-cycle.
  bit          stalled = 0;
  logic [16:0] hold_addr;
  logic [3:0]  hold_op;
  logic [31:0] hold_data;
  wr_t         pe;

  always @(negedge clk) begin
    if (!chk_en) begin
      stalled = 0;
      final_done_due = -1;
    end else begin
      check("done_timing", done, (cyc == empty_done_due) || (cyc == final_done_due));
      if (done) done_cnt++;
      check("ready_vs_busy", cmd_ready, !busy);
      if (fillrect_rts_out) begin
        check("op_nonzero", fillrect_op != 4'b0000, 1'b1);
        if (stalled) begin
          check("stall_addr", fillrect_addr, hold_addr);
          check("stall_op", fillrect_op, hold_op);
          check("stall_data", fillrect_wrdata, hold_data);
        end
        if (fillrect_rtr_in) begin
          stalled = 0;
          log_q.push_back('{addr: fillrect_addr, op: fillrect_op, data: fillrect_wrdata});
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write got addr %0d op %b expected none", fillrect_addr,
                     fillrect_op);
          end else begin
            pe = exp_q.pop_front();
            check("wr_addr", fillrect_addr, pe.addr);
            check("wr_op", fillrect_op, pe.op);
            check("wr_data", fillrect_wrdata, pe.data);
            if (exp_q.size() == 0) final_done_due = cyc + 1;
          end
        end else begin
          stalled   = 1;
          hold_addr = fillrect_addr;
          hold_op   = fillrect_op;
          hold_data = fillrect_wrdata;
        end
      end else begin
        stalled = 0;
      end
    end
  end

  task automatic send_cmd(input int x0, input int y0, input int w, input int h,
                          input logic [7:0] c);
    bit acc;
    bit emp;
    acc = 0;
    @(posedge clk);
    #2;
    cmd_valid = 1'b1;
    cmd_x0    = 10'(x0);
    cmd_y0    = 9'(y0);
    cmd_w     = 10'(w);
    cmd_h     = 9'(h);
    cmd_color = c;
    for (int i = 0; i < 5000 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = 1;
        model_cmd(x0, y0, w, h, c, emp);
        if (emp) empty_done_due = cyc + 1;
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got cmd_ready 0 expected 1");
    end
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got done 0 expected 1");
    end
    @(negedge clk);
  endtask

  task automatic check_case2(input string tag);
    int ea[6];
    logic [3:0] eo[6];
    ea = '{0, 1, 2, 160, 161, 162};
    eo = '{4'b1000, 4'b1111, 4'b0001, 4'b1000, 4'b1111, 4'b0001};
    check({tag, "_count"}, log_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) begin
        check({tag, "_addr"}, log_q[i].addr, 17'(ea[i]));
        check({tag, "_op"}, log_q[i].op, eo[i]);
      end
    end
  endtask

  int d0;

  initial begin
    rst_ = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0 = '0;
    cmd_y0 = '0;
    cmd_w = '0;
    cmd_h = '0;
    cmd_color = '0;
    fillrect_rtr_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rts", fillrect_rts_out, 1'b0);
    check("rst_op", fillrect_op, 4'b0);
    check("rst_addr", fillrect_addr, 17'd0);
    check("rst_data", fillrect_wrdata, 32'd0);
    rst_ = 1'b1;
    @(negedge clk);
    chk_en = 1;

    // single pixel
    rtr_mode = 0;
    log_q.delete();
    d0 = done_cnt;
    send_cmd(5, 2, 1, 1, 8'hAB);
    wait_done();
    check("c1_count", log_q.size(), 1);
    if (log_q.size() > 0) begin
      check("c1_addr", log_q[0].addr, 17'd321);
      check("c1_op", log_q[0].op, 4'b0010);
      check("c1_data", log_q[0].data, 32'hABABABAB);
    end
    check("c1_dones", done_cnt - d0, 1);

    // two rows spanning three words
    log_q.delete();
    d0 = done_cnt;
    send_cmd(3, 0, 6, 2, 8'h5C);
    wait_done();
    check_case2("c2");
    check("c2_dones", done_cnt - d0, 1);

    // clipped at the bottom-right corner
    log_q.delete();
    send_cmd(636, 479, 10, 5, 8'h11);
    wait_done();
    check("c3_count", log_q.size(), 1);
    if (log_q.size() > 0) begin
      check("c3_addr", log_q[0].addr, 17'd76799);
      check("c3_op", log_q[0].op, 4'b1111);
    end

    // empty commands
    log_q.delete();
    d0 = done_cnt;
    send_cmd(10, 10, 0, 3, 8'h22);
    wait_done();
    send_cmd(10, 500, 8, 3, 8'h33);
    wait_done();
    check("c4_count", log_q.size(), 0);
    check("c4_dones", done_cnt - d0, 2);

    // stalls on the arbiter side
    rtr_mode = 2;
    pidx = 0;
    log_q.delete();
    send_cmd(3, 0, 6, 2, 8'h77);
    wait_done();
    check_case2("c5");

    // reset in the middle of emission
    log_q.delete();
    send_cmd(3, 0, 6, 2, 8'h99);
    for (int i = 0; i < 200 && log_q.size() < 2; i++) @(negedge clk);
    @(posedge clk);
    #3;
    chk_en = 0;
    rst_ = 1'b0;
    #1;
    check("c6_rts", fillrect_rts_out, 1'b0);
    check("c6_busy", busy, 1'b0);
    check("c6_done", done, 1'b0);
    check("c6_ready", cmd_ready, 1'b1);
    exp_q.delete();
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    chk_en = 1;
    rtr_mode = 0;
    repeat (4) @(negedge clk);
    log_q.delete();
    send_cmd(5, 2, 1, 1, 8'hAB);
    wait_done();
    check("c6_after_count", log_q.size(), 1);
    if (log_q.size() > 0) check("c6_after_addr", log_q[0].addr, 17'd321);

    // randomized stream, commands presented back to back
    rtr_mode = 1;
    for (int n = 0; n < 40; n++) begin
      int rw;
      rw = (($urandom % 8) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 40);
      send_cmd($urandom_range(0, 660), $urandom_range(0, 490), rw, $urandom_range(0, 4),
               8'($urandom));
    end
    wait_done();
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("idle_at_end", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
